// File: rtl/uart_alu_parser_if.sv
// Byte-stream, echo-stream and operand-stream handshakes of the UART packet parser.
// The slave modport is the parser's view; master is the surrounding system's.
interface uart_alu_parser_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [1:0]  op_o;
    logic [31:0] operand_o;
    logic        operand_valid_o;
    logic        operand_last_o;
    logic        operand_ready_i;
    logic        error_o;

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i, operand_ready_i,
        output rx_ready_o, tx_data_o, tx_valid_o, op_o, operand_o,
               operand_valid_o, operand_last_o, error_o
    );

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i, operand_ready_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, op_o, operand_o,
               operand_valid_o, operand_last_o, error_o
    );
endinterface

// File: rtl/uart_alu_parser.sv
// Packet framer between the UART receiver and the ALU: decodes the 4-byte header,
// echoes payloads, packs arithmetic payloads into 32-bit operands, flags bad packets.
module uart_alu_parser #(
    parameter logic [7:0] OP_ECHO = 8'hEC,
    parameter logic [7:0] OP_ADD  = 8'h10,
    parameter logic [7:0] OP_MUL  = 8'h11,
    parameter logic [7:0] OP_DIV  = 8'h12
) (
    input  logic            clk_i,
    input  logic            rst_i,
    uart_alu_parser_if.slave bus
);

    localparam logic [2:0] ST_OPCODE  = 3'd0;
    localparam logic [2:0] ST_RSVD    = 3'd1;
    localparam logic [2:0] ST_LEN_LO  = 3'd2;
    localparam logic [2:0] ST_LEN_HI  = 3'd3;
    localparam logic [2:0] ST_ECHO    = 3'd4;
    localparam logic [2:0] ST_OPERAND = 3'd5;
    localparam logic [2:0] ST_DRAIN   = 3'd6;

    logic [2:0]  state_r;
    logic [7:0]  opcode_r;
    logic [7:0]  len_lo_r;
    logic [15:0] count_r;
    logic [1:0]  byte_idx_r;
    logic [1:0]  op_r;
    logic        error_r;
    logic [7:0]  tx_data_r;
    logic        tx_valid_r;
    logic [31:0] operand_r;
    logic        operand_valid_r;
    logic        operand_last_r;

    logic        rx_ready_s;
    logic        rx_accept_s;
    logic [15:0] length_s;
    logic        last_byte_s;
    logic        is_arith_s;
    logic [1:0]  op_code_s;
    logic        echo_load_s;
    logic        operand_byte_s;
    logic        operand_done_s;

    assign rx_accept_s    = bus.rx_valid_i && rx_ready_s;
    assign length_s       = {bus.rx_data_i, len_lo_r};
    assign last_byte_s    = (count_r == 16'd1);
    assign echo_load_s    = rx_accept_s && (state_r == ST_ECHO);
    assign operand_byte_s = rx_accept_s && (state_r == ST_OPERAND);
    assign operand_done_s = operand_byte_s && (byte_idx_r == 2'd3);

    // Byte acceptance: OPCODE waits for a pending operand so op_o cannot change under it.
    always_comb begin
        rx_ready_s = 1'b1;
        case (state_r)
            ST_OPCODE:  rx_ready_s = !operand_valid_r;
            ST_ECHO:    rx_ready_s = !tx_valid_r || bus.tx_ready_i;
            ST_OPERAND: rx_ready_s = !operand_valid_r || bus.operand_ready_i;
            default:    rx_ready_s = 1'b1;
        endcase
    end

    // Opcode classification into the ALU operation code.
    always_comb begin
        is_arith_s = 1'b1;
        op_code_s  = 2'd0;
        case (opcode_r)
            OP_ADD:  op_code_s = 2'd0;
            OP_MUL:  op_code_s = 2'd1;
            OP_DIV:  op_code_s = 2'd2;
            default: begin
                is_arith_s = 1'b0;
                op_code_s  = 2'd0;
            end
        endcase
    end

    // Header decode, payload counting and error pulse generation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_OPCODE;
            opcode_r   <= 8'h00;
            len_lo_r   <= 8'h00;
            count_r    <= 16'd0;
            byte_idx_r <= 2'd0;
            op_r       <= 2'd0;
            error_r    <= 1'b0;
        end else begin
            error_r <= 1'b0;
            if (rx_accept_s) begin
                case (state_r)
                    ST_OPCODE: begin
                        opcode_r <= bus.rx_data_i;
                        state_r  <= ST_RSVD;
                    end
                    ST_RSVD:   state_r <= ST_LEN_LO;
                    ST_LEN_LO: begin
                        len_lo_r <= bus.rx_data_i;
                        state_r  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        byte_idx_r <= 2'd0;
                        count_r    <= (length_s < 16'd4) ? 16'd0 : (length_s - 16'd4);
                        if (length_s < 16'd4) begin
                            error_r <= 1'b1;
                            state_r <= ST_OPCODE;
                        end else if (length_s == 16'd4) begin
                            state_r <= ST_OPCODE;
                        end else if (opcode_r == OP_ECHO) begin
                            state_r <= ST_ECHO;
                        end else if (is_arith_s) begin
                            op_r    <= op_code_s;
                            state_r <= ST_OPERAND;
                        end else begin
                            error_r <= 1'b1;
                            state_r <= ST_DRAIN;
                        end
                    end
                    ST_OPERAND: begin
                        count_r    <= count_r - 16'd1;
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (last_byte_s) begin
                            state_r <= ST_OPCODE;
                            // A packet ending mid-word leaves a discarded fragment.
                            error_r <= (byte_idx_r != 2'd3);
                        end
                    end
                    ST_ECHO, ST_DRAIN: begin
                        count_r <= count_r - 16'd1;
                        if (last_byte_s) begin
                            state_r <= ST_OPCODE;
                        end
                    end
                    default: state_r <= ST_OPCODE;
                endcase
            end
        end
    end

    // One-entry echo output register; reloads in the same cycle it drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else if (echo_load_s) begin
            tx_data_r  <= bus.rx_data_i;
            tx_valid_r <= 1'b1;
        end else if (bus.tx_ready_i) begin
            tx_valid_r <= 1'b0;
        end
    end

    // Little-endian operand assembly and operand handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            operand_r       <= 32'h0000_0000;
            operand_valid_r <= 1'b0;
            operand_last_r  <= 1'b0;
        end else begin
            if (operand_valid_r && bus.operand_ready_i) begin
                operand_valid_r <= 1'b0;
                operand_last_r  <= 1'b0;
            end
            if (operand_byte_s) begin
                operand_r[{byte_idx_r, 3'b000} +: 8] <= bus.rx_data_i;
            end
            if (operand_done_s) begin
                operand_valid_r <= 1'b1;
                operand_last_r  <= last_byte_s;
            end
        end
    end

    assign bus.rx_ready_o      = rx_ready_s;
    assign bus.tx_data_o       = tx_data_r;
    assign bus.tx_valid_o      = tx_valid_r;
    assign bus.op_o            = op_r;
    assign bus.operand_o       = operand_r;
    assign bus.operand_valid_o = operand_valid_r;
    assign bus.operand_last_o  = operand_last_r;
    assign bus.error_o         = error_r;

endmodule
